// File: rtl/rt_pkg.sv
// ============================================================================
//  Module   : rt_pkg
//  Brief    : Shared types and command-word field constants for rt_cmd_dispatch
//  Revision : 1.0
// ============================================================================
`default_nettype none

package rt_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_CHECK     = 2'd1,
        S_WAIT_RISE = 2'd2,
        S_WAIT_FALL = 2'd3
    } state_t;

    localparam logic [4:0] BCAST_ADDR = 5'd31;
    localparam logic [4:0] MODE_SA0   = 5'd0;
    localparam logic [4:0] MODE_SA31  = 5'd31;

    localparam int ADDR_MSB  = 15;
    localparam int ADDR_LSB  = 11;
    localparam int TR_BIT    = 10;
    localparam int SA_MSB    = 9;
    localparam int SA_LSB    = 5;
    localparam int FIELD_MSB = 4;
    localparam int FIELD_LSB = 0;

    function automatic logic is_mode_sa(input logic [4:0] sa);
        return (sa == MODE_SA0) || (sa == MODE_SA31);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rt_sat_cnt.sv
// ============================================================================
//  Module   : rt_sat_cnt
//  Brief    : Saturating up-counter with increment enable
//  Revision : 1.0
// ============================================================================
`default_nettype none

module rt_sat_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/rt_cmd_dispatch.sv
// ============================================================================
//  Module   : rt_cmd_dispatch
//  Brief    : RT command-word checker, device start strobes and busy timeout
//  Revision : 1.0
// ============================================================================
`default_nettype none

module rt_cmd_dispatch
    import rt_pkg::*;
#(
    parameter logic [4:0]  ADDRESS  = 5'd1,
    parameter bit          BCAST_EN = 1'b1,
    parameter logic [15:0] TIMEOUT  = 16'd50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx_done,
    input  logic [15:0] rx_data,
    input  logic        rx_cd,
    input  logic        p_error,
    input  logic        dev_busy,
    output logic        start_rx,
    output logic        start_tx,
    output logic        mode_req,
    output logic [4:0]  mode_code,
    output logic        bcast,
    output logic [4:0]  sub_addr,
    output logic        timeout,
    output logic [7:0]  cmd_cnt,
    output logic [7:0]  err_cnt
);

    localparam logic [15:0] c_TO_LAST = TIMEOUT - 16'd1;

    state_t      state_q;
    logic [15:0] cmd_q;
    logic        perr_q;
    logic [15:0] to_cnt_q;
    logic        start_rx_q;
    logic        start_tx_q;
    logic        mode_req_q;
    logic        timeout_q;
    logic        bcast_q;
    logic [4:0]  mode_code_q;
    logic [4:0]  sub_addr_q;

    logic [4:0]  w_addr;
    logic [4:0]  w_sa;
    logic        w_tr;
    logic        w_is_bcast;
    logic        w_match;
    logic        w_is_mode;
    logic        w_illegal;
    logic        w_in_check;
    logic        w_accept;
    logic        w_reject;
    logic        w_new_cmd;

    assign w_addr     = cmd_q[ADDR_MSB:ADDR_LSB];
    assign w_sa       = cmd_q[SA_MSB:SA_LSB];
    assign w_tr       = cmd_q[TR_BIT];
    assign w_is_bcast = BCAST_EN && (w_addr == BCAST_ADDR);
    assign w_match    = (w_addr == ADDRESS) || w_is_bcast;
    assign w_is_mode  = is_mode_sa(w_sa);
    // Nobody may answer a broadcast transmit, so only broadcast mode codes are legal with T/R=1
    assign w_illegal  = perr_q || (w_is_bcast && w_tr && !w_is_mode);
    assign w_in_check = (state_q == S_CHECK);
    assign w_accept   = w_in_check && w_match && !w_illegal;
    assign w_reject   = w_in_check && w_match && w_illegal;
    assign w_new_cmd  = rx_done && rx_cd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            perr_q      <= 1'b0;
            to_cnt_q    <= '0;
            start_rx_q  <= 1'b0;
            start_tx_q  <= 1'b0;
            mode_req_q  <= 1'b0;
            timeout_q   <= 1'b0;
            bcast_q     <= 1'b0;
            mode_code_q <= '0;
            sub_addr_q  <= '0;
        end else begin
            start_rx_q <= 1'b0;
            start_tx_q <= 1'b0;
            mode_req_q <= 1'b0;
            timeout_q  <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (w_new_cmd) begin
                        cmd_q   <= rx_data;
                        perr_q  <= p_error;
                        state_q <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    state_q <= S_IDLE;
                    if (w_accept) begin
                        bcast_q    <= w_is_bcast;
                        sub_addr_q <= w_sa;
                        if (w_is_mode) begin
                            mode_req_q  <= 1'b1;
                            mode_code_q <= cmd_q[FIELD_MSB:FIELD_LSB];
                        end else begin
                            start_rx_q <= !w_tr;
                            start_tx_q <= w_tr;
                            to_cnt_q   <= '0;
                            state_q    <= S_WAIT_RISE;
                        end
                    end
                end

                S_WAIT_RISE, S_WAIT_FALL: begin
                    // A superseding command outranks a timeout expiring in the same cycle
                    if (w_new_cmd) begin
                        cmd_q    <= rx_data;
                        perr_q   <= p_error;
                        to_cnt_q <= '0;
                        state_q  <= S_CHECK;
                    end else if (to_cnt_q == c_TO_LAST) begin
                        timeout_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 16'd1;
                        if ((state_q == S_WAIT_RISE) && dev_busy) begin
                            state_q <= S_WAIT_FALL;
                        end else if ((state_q == S_WAIT_FALL) && !dev_busy) begin
                            state_q <= S_IDLE;
                        end
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    rt_sat_cnt #(.WIDTH(8)) u_cmd_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (w_accept),
        .cnt_o   (cmd_cnt)
    );

    rt_sat_cnt #(.WIDTH(8)) u_err_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (w_reject),
        .cnt_o   (err_cnt)
    );

    assign start_rx  = start_rx_q;
    assign start_tx  = start_tx_q;
    assign mode_req  = mode_req_q;
    assign mode_code = mode_code_q;
    assign bcast     = bcast_q;
    assign sub_addr  = sub_addr_q;
    assign timeout   = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_rt_cmd_dispatch.sv
// ============================================================================
//  Module   : tb_rt_cmd_dispatch
//  Brief    : Self-checking bench for rt_cmd_dispatch (vector table, directed, random)
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rt_cmd_dispatch;

    localparam int K_NONE = 0;
    localparam int K_RX   = 1;
    localparam int K_TX   = 2;
    localparam int K_MODE = 3;
    localparam int K_ERR  = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rx_done;
    logic [15:0] rx_data;
    logic        rx_cd;
    logic        p_error;
    logic        dev_busy;
    logic        start_rx;
    logic        start_tx;
    logic        mode_req;
    logic [4:0]  mode_code;
    logic        bcast;
    logic [4:0]  sub_addr;
    logic        timeout;
    logic [7:0]  cmd_cnt;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tout_seen = 0;
    int tout_cyc = 0;
    int strobe_cyc = 0;

    int         m_cmd = 0;
    int         m_err = 0;
    logic       m_bcast = 1'b0;
    logic [4:0] m_sa = '0;
    logic [4:0] m_mc = '0;

    typedef struct {
        logic [15:0] cmd;
        logic        pe;
        logic        cd;
        logic [2:0]  exp_strb;
        logic        exp_cmd_inc;
        logic        exp_err_inc;
    } vec_t;

    vec_t tbl [11];

    rt_cmd_dispatch #(
        .ADDRESS  (5'd1),
        .BCAST_EN (1'b1),
        .TIMEOUT  (16'd100)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_done   (rx_done),
        .rx_data   (rx_data),
        .rx_cd     (rx_cd),
        .p_error   (p_error),
        .dev_busy  (dev_busy),
        .start_rx  (start_rx),
        .start_tx  (start_tx),
        .mode_req  (mode_req),
        .mode_code (mode_code),
        .bcast     (bcast),
        .sub_addr  (sub_addr),
        .timeout   (timeout),
        .cmd_cnt   (cmd_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (timeout === 1'b1) begin
            tout_seen = tout_seen + 1;
            tout_cyc  = cyc;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Outcome of one command word, derived directly from the field rules
    function automatic int ref_kind(input logic [15:0] w, input logic pe, input logic cd);
        int v, a, tr, sa;
        v  = int'(w);
        a  = (v >> 11) & 31;
        tr = (v >> 10) & 1;
        sa = (v >> 5) & 31;
        if (!cd) return K_NONE;
        if (a != 1 && a != 31) return K_NONE;
        if (pe) return K_ERR;
        if (a == 31 && tr == 1 && sa != 0 && sa != 31) return K_ERR;
        if (sa == 0 || sa == 31) return K_MODE;
        return (tr == 1) ? K_TX : K_RX;
    endfunction

    function automatic logic [2:0] kind_strb(input int k);
        case (k)
            K_RX:    return 3'b100;
            K_TX:    return 3'b010;
            K_MODE:  return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic model_reset();
        m_cmd   = 0;
        m_err   = 0;
        m_bcast = 1'b0;
        m_sa    = '0;
        m_mc    = '0;
    endtask

    // Called just after a falling edge; rx_done is sampled on the next rising edge
    task automatic send(input logic [15:0] w, input logic pe, input logic cd,
                        input logic [2:0] es, input logic ci, input logic ei,
                        input string tag);
        rx_data = w;
        p_error = pe;
        rx_cd   = cd;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        p_error = 1'b0;
        chk({tag, ":early"}, int'({start_rx, start_tx, mode_req}), 0);
        @(negedge clk);
        strobe_cyc = cyc;
        chk({tag, ":strobe"}, int'({start_rx, start_tx, mode_req}), int'(es));
        if (ci) begin
            if (m_cmd < 255) m_cmd = m_cmd + 1;
            m_bcast = (w[15:11] == 5'd31);
            m_sa    = w[9:5];
        end
        if (ei && m_err < 255) m_err = m_err + 1;
        if (es == 3'b001) m_mc = w[4:0];
        @(negedge clk);
        chk({tag, ":pulse"}, int'({start_rx, start_tx, mode_req}), 0);
        chk({tag, ":cmd_cnt"}, int'(cmd_cnt), m_cmd);
        chk({tag, ":err_cnt"}, int'(err_cnt), m_err);
        chk({tag, ":bcast"}, int'(bcast), int'(m_bcast));
        chk({tag, ":sub_addr"}, int'(sub_addr), int'(m_sa));
        chk({tag, ":mode_code"}, int'(mode_code), int'(m_mc));
    endtask

    task automatic send_model(input logic [15:0] w, input logic pe, input logic cd, input string tag);
        int k;
        k = ref_kind(w, pe, cd);
        send(w, pe, cd, kind_strb(k), (k == K_RX || k == K_TX || k == K_MODE), (k == K_ERR), tag);
    endtask

    task automatic busy_pulse(input int len);
        if (len > 0) begin
            dev_busy = 1'b1;
            repeat (len) @(negedge clk);
            dev_busy = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic wait_timeout(input int n0, input int budget, input string tag);
        int i;
        i = 0;
        while (tout_seen == n0 && i < budget) begin
            @(negedge clk);
            i = i + 1;
        end
        chk({tag, ":fired"}, tout_seen - n0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n0, s, k;
        logic [15:0] w;

        tbl[0]  = '{16'h0823, 1'b0, 1'b1, 3'b100, 1'b1, 1'b0};
        tbl[1]  = '{16'h0C22, 1'b0, 1'b1, 3'b010, 1'b1, 1'b0};
        tbl[2]  = '{16'h1023, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0};
        tbl[3]  = '{16'h0811, 1'b0, 1'b1, 3'b001, 1'b1, 1'b0};
        tbl[4]  = '{16'hF823, 1'b0, 1'b1, 3'b100, 1'b1, 1'b0};
        tbl[5]  = '{16'hFC23, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1};
        tbl[6]  = '{16'h0823, 1'b1, 1'b1, 3'b000, 1'b0, 1'b1};
        tbl[7]  = '{16'h0823, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0};
        tbl[8]  = '{16'hFC11, 1'b0, 1'b1, 3'b001, 1'b1, 1'b0};
        tbl[9]  = '{16'h0BE5, 1'b0, 1'b1, 3'b001, 1'b1, 1'b0};
        tbl[10] = '{16'h7C22, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0};

        reset_n  = 1'b0;
        rx_done  = 1'b0;
        rx_data  = '0;
        rx_cd    = 1'b0;
        p_error  = 1'b0;
        dev_busy = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst:strobes", int'({start_rx, start_tx, mode_req, timeout, bcast}), 0);
        chk("rst:mode_code", int'(mode_code), 0);
        chk("rst:sub_addr", int'(sub_addr), 0);
        chk("rst:cmd_cnt", int'(cmd_cnt), 0);
        chk("rst:err_cnt", int'(err_cnt), 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            send(tbl[i].cmd, tbl[i].pe, tbl[i].cd, tbl[i].exp_strb,
                 tbl[i].exp_cmd_inc, tbl[i].exp_err_inc, $sformatf("vec%0d", i));
            if (tbl[i].exp_strb[2] || tbl[i].exp_strb[1]) busy_pulse(3);
        end
        chk("vec:no_timeout", tout_seen, 0);

        // Receive command with a 40-cycle device busy window: no timeout
        send(16'h0823, 1'b0, 1'b1, 3'b100, 1'b1, 1'b0, "busy40");
        busy_pulse(40);
        repeat (120) @(negedge clk);
        chk("busy40:no_timeout", tout_seen, 0);

        // Reset asserted while the command sits in CHECK drops the strobe
        rx_data = 16'h0823;
        rx_cd   = 1'b1;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst:strobes", int'({start_rx, start_tx, mode_req, timeout, bcast}), 0);
        chk("midrst:cnts", int'({cmd_cnt, err_cnt, sub_addr, mode_code}), 0);
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
        chk("midrst:dropped", int'({start_rx, start_tx, mode_req}), 0);
        send(16'h0823, 1'b0, 1'b1, 3'b100, 1'b1, 1'b0, "postrst");
        busy_pulse(2);

        // Stuck-busy timeout, busy already high at strobe time
        dev_busy = 1'b1;
        n0 = tout_seen;
        send(16'h0823, 1'b0, 1'b1, 3'b100, 1'b1, 1'b0, "toA");
        s = strobe_cyc;
        wait_timeout(n0, 300, "toA");
        chk("toA:delay", tout_cyc - s, 100);
        @(negedge clk);
        chk("toA:one_cycle", int'(timeout), 0);

        // Superseding command during WAIT_FALL restarts the timeout window
        n0 = tout_seen;
        send(16'h0823, 1'b0, 1'b1, 3'b100, 1'b1, 1'b0, "toB1");
        repeat (50) @(negedge clk);
        send(16'h0C22, 1'b0, 1'b1, 3'b010, 1'b1, 1'b0, "toB2");
        s = strobe_cyc;
        wait_timeout(n0, 300, "toB");
        chk("toB:delay", tout_cyc - s, 100);

        // Command arriving on the very cycle the timeout would fire wins
        @(negedge clk);
        send(16'h0823, 1'b0, 1'b1, 3'b100, 1'b1, 1'b0, "toC1");
        s = strobe_cyc;
        while (cyc < s + 99) @(negedge clk);
        n0 = tout_seen;
        send(16'h0C22, 1'b0, 1'b1, 3'b010, 1'b1, 1'b0, "toC2");
        chk("toC:no_pulse", tout_seen - n0, 0);
        s = strobe_cyc;
        wait_timeout(n0, 300, "toC");
        chk("toC:delay", tout_cyc - s, 100);
        dev_busy = 1'b0;
        repeat (2) @(negedge clk);

        // Parity errors saturate err_cnt at 255
        for (int i = 0; i < 256; i++) begin
            send(16'h0823, 1'b1, 1'b1, 3'b000, 1'b0, 1'b1, "perr");
        end
        chk("perr:sat", int'(err_cnt), 255);

        // Randomized commands against the reference model
        n0 = tout_seen;
        for (int i = 0; i < 200; i++) begin
            w = 16'($urandom);
            k = int'($urandom_range(0, 3));
            if (k == 0) w[15:11] = 5'd1;
            else if (k == 1) w[15:11] = 5'd31;
            k = int'($urandom_range(0, 3));
            if (k == 0) w[9:5] = 5'd0;
            else if (k == 1) w[9:5] = 5'd31;
            send_model(w, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0),
                       $sformatf("rnd%0d", i));
            if (start_rx === 1'b0 && ref_kind(w, 1'b0, 1'b1) inside {K_RX, K_TX})
                busy_pulse(int'($urandom_range(0, 4)));
        end
        chk("rnd:no_timeout", tout_seen - n0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
